imem_loader: RTL and testbench

//   Writer side of the instruction memory that the fetch unit reads. Accepts a framed byte

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory.
// Frame: LEN_LO, LEN_HI, N*4 little-endian data bytes, CSUM (XOR of data bytes).
// Holds the cpu in reset until a frame with a good checksum has been written.
module imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              reload,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          idx_q, idx_d;
    logic [23:0]         word_q, word_d;
    logic [7:0]          acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [31:0]         wr_data_d;
    logic                s_ready_d, done_d, error_d, cpu_hold_d;
    logic [15:0]         len_full;
    logic                xfer;

    // State and output registers; reload behaves exactly like reset and drops any pending write
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state_q      <= S_LEN_LO;
            len_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            acc_q        <= '0;
            words_loaded <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            s_ready      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            acc_q        <= acc_d;
            words_loaded <= cnt_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            s_ready      <= s_ready_d;
            done         <= done_d;
            error        <= error_d;
            cpu_hold     <= cpu_hold_d;
        end
    end

    // Next-state, word assembly and registered-output decode
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        word_d    = word_q;
        acc_d     = acc_q;
        cnt_d     = words_loaded;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        len_full  = {s_data, len_q[7:0]};
        xfer      = s_valid && s_ready;

        case (state_q)
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = s_data;
                    if (32'(len_full) > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    acc_d = acc_q ^ s_data;
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: word_d[7:0]   = s_data;
                        2'd1: word_d[15:8]  = s_data;
                        2'd2: word_d[23:16] = s_data;
                        default: begin
                            // Last byte of a word: write it out and count it
                            wr_en_d   = 1'b1;
                            wr_addr_d = words_loaded[ADDR_W-1:0];
                            wr_data_d = {s_data, word_q};
                            cnt_d     = words_loaded + CNT_W'(1);
                            if (16'(words_loaded) + 16'd1 == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (s_data == acc_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_LEN_LO;
            end
        endcase

        s_ready_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                     (state_d == S_DATA)   || (state_d == S_CSUM);
        done_d     = (state_d == S_RUN);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_RUN);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (ADDR_W = 10).
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              reload;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks;
    int failures;
    int wr_count;
    int bad_wr;
    int wr_base;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .reload       (reload),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count write strobes and flag any strobe while the loader is not accepting
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_count++;
        if (wr_en === 1'b1 && s_ready !== 1'b1) bad_wr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; returns right after the transfer edge
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  n;
        bit  xfer;
        n = 0;
        forever begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = s_valid ? b : 8'($urandom);
            xfer    = s_valid && s_ready;
            @(posedge clk);
            @(negedge clk);
            if (xfer) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $error("FAIL send_timeout observed=stalled expected=transfer");
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    // Sends one word LSB first and checks the write strobe that follows it
    task automatic send_word(input logic [31:0] w, input int idx, input bit rnd, input string tag);
        send_byte(w[7:0], rnd);
        send_byte(w[15:8], rnd);
        send_byte(w[23:16], rnd);
        send_byte(w[31:24], rnd);
        check({tag, "_wr_en"},   wr_en,   1);
        check({tag, "_wr_addr"}, wr_addr, idx);
        check({tag, "_wr_data"}, wr_data, w);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wr_count = 0;
        bad_wr   = 0;
        rst      = 1'b1;
        reload   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_s_ready", s_ready, 1);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_words", words_loaded, 0);
        rst = 1'b0;
        idle(1);

        // 1: N=2, good checksum 44^33^22^11^88^77^66^55 = 0x88
        wr_base = wr_count;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0, 0, "t1_w0");
        send_word(32'h55667788, 1, 0, "t1_w1");
        check("t1_hold_before_csum", cpu_hold, 1);
        send_byte(8'h88, 0);
        check("t1_done", done, 1);
        check("t1_cpu_hold", cpu_hold, 0);
        check("t1_error", error, 0);
        check("t1_s_ready", s_ready, 0);
        check("t1_words", words_loaded, 2);
        // Bytes offered in RUN are ignored
        s_valid = 1'b1;
        s_data  = 8'h5A;
        idle(3);
        s_valid = 1'b0;
        check("t1_run_ignore_done", done, 1);
        check("t1_run_ignore_words", words_loaded, 2);
        check("t1_wr_count", wr_count - wr_base, 2);

        // 2: same frame, bad checksum
        pulse_reload();
        check("t2_reload_done", done, 0);
        check("t2_reload_words", words_loaded, 0);
        check("t2_reload_s_ready", s_ready, 1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0, 0, "t2_w0");
        send_word(32'h55667788, 1, 0, "t2_w1");
        send_byte(8'h89, 0);
        check("t2_error", error, 1);
        check("t2_done", done, 0);
        check("t2_cpu_hold", cpu_hold, 1);
        check("t2_s_ready", s_ready, 0);
        check("t2_words", words_loaded, 2);

        // 3: empty frame, then length boundaries
        pulse_reload();
        wr_base = wr_count;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t3_n0_done", done, 1);
        check("t3_n0_words", words_loaded, 0);
        check("t3_n0_no_wr", wr_count - wr_base, 0);
        pulse_reload();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        check("t3_n1024_error", error, 0);
        check("t3_n1024_s_ready", s_ready, 1);
        pulse_reload();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        check("t3_n1025_error", error, 1);
        check("t3_n1025_s_ready", s_ready, 0);
        check("t3_n1025_cpu_hold", cpu_hold, 1);

        // 4: N=4 with s_valid toggling randomly; checksum 0x26
        pulse_reload();
        wr_base = wr_count;
        send_byte(8'h04, 1);
        send_byte(8'h00, 1);
        send_word(32'hDEADBEEF, 0, 1, "t4_w0");
        send_word(32'h01020304, 1, 1, "t4_w1");
        send_word(32'hA5A55A5A, 2, 1, "t4_w2");
        send_word(32'hFFFF0000, 3, 1, "t4_w3");
        send_byte(8'h26, 1);
        idle(2);
        check("t4_done", done, 1);
        check("t4_words", words_loaded, 4);
        check("t4_wr_count", wr_count - wr_base, 4);
        check("t4_wr_while_not_ready", bad_wr, 0);

        // 5: reload after 6 data bytes (reload-cycle byte discarded), then N=1 frame
        pulse_reload();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'hD4C3B2A1, 0, 0, "t5_w0");
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        s_valid = 1'b1;
        s_data  = 8'h01;
        pulse_reload();
        s_valid = 1'b0;
        check("t5_reload_words", words_loaded, 0);
        check("t5_reload_hold", cpu_hold, 1);
        check("t5_reload_s_ready", s_ready, 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0, 0, "t5_w0b");
        send_byte(8'hC9, 0);
        check("t5_done", done, 1);
        check("t5_words", words_loaded, 1);

        // 6: rst on the last byte of a word cancels the write
        pulse_reload();
        wr_base = wr_count;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        send_byte(8'hFE, 0);
        s_valid = 1'b1;
        s_data  = 8'hCA;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_words", words_loaded, 0);
        check("t6_rst_s_ready", s_ready, 1);
        check("t6_rst_hold", cpu_hold, 1);
        idle(2);
        check("t6_rst_no_wr", wr_count - wr_base, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0, 0, "t6_w0");
        send_byte(8'hC9, 0);
        check("t6_done", done, 1);
        pulse_reload();
        check("t6_reload_done", done, 0);
        check("t6_reload_hold", cpu_hold, 1);
        check("t6_reload_s_ready", s_ready, 1);
        check("t6_reload_error", error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
